// File: rtl/seg_scan_ctrl.sv
// Six-digit common-anode 7-segment scan controller with a per-digit register
// file, programmable on-time / dead-time and per-digit flashing.
module seg_scan_ctrl #(
  parameter int SCAN_DIV     = 50_000,
  parameter int BLANK_CYC    = 500,
  parameter int FLASH_FRAMES = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       disp_en,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  input  logic       wr_blank,
  input  logic [5:0] flash_en,
  output logic [7:0] dig,
  output logic [5:0] sel
);

  localparam int CNT_MAX = ((SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC) - 1;
  localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam int FRM_W   = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  localparam bit              HAS_BLANK  = (BLANK_CYC > 0);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [FRM_W-1:0] FRAME_LAST = FRM_W'(FLASH_FRAMES - 1);

  typedef enum logic {SHOW, BLANK} state_t;
  typedef enum logic {PHASE_ON, PHASE_OFF} phase_t;

  state_t           state, state_nx;
  phase_t           phase, phase_nx;
  logic [2:0]       idx, idx_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [FRM_W-1:0] frame_cnt, frame_nx;
  logic [5:0]       sel_nx;
  logic [7:0]       dig_nx;
  logic             advance;
  logic             dark;

  logic [3:0] value [0:5];
  logic [5:0] dp;
  logic [5:0] blank;

  // Segment patterns for {g,f,e,d,c,b,a}, active low.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0:    seg_decode = 7'h40;
      4'h1:    seg_decode = 7'h79;
      4'h2:    seg_decode = 7'h24;
      4'h3:    seg_decode = 7'h30;
      4'h4:    seg_decode = 7'h19;
      4'h5:    seg_decode = 7'h12;
      4'h6:    seg_decode = 7'h02;
      4'h7:    seg_decode = 7'h78;
      4'h8:    seg_decode = 7'h00;
      4'h9:    seg_decode = 7'h10;
      4'hA:    seg_decode = 7'h08;
      4'hB:    seg_decode = 7'h03;
      4'hC:    seg_decode = 7'h46;
      4'hD:    seg_decode = 7'h21;
      4'hE:    seg_decode = 7'h06;
      default: seg_decode = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '{default: 4'h0};
      dp    <= '0;
      blank <= '0;
    end else if (wr_en && (wr_addr <= 3'd5)) begin
      value[wr_addr] <= wr_data;
      dp[wr_addr]    <= wr_dp;
      blank[wr_addr] <= wr_blank;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SHOW;
      phase     <= PHASE_ON;
      idx       <= '0;
      cnt       <= '0;
      frame_cnt <= '0;
      sel       <= 6'b111111;
      dig       <= 8'hFF;
    end else begin
      state     <= state_nx;
      phase     <= phase_nx;
      idx       <= idx_nx;
      cnt       <= cnt_nx;
      frame_cnt <= frame_nx;
      sel       <= sel_nx;
      dig       <= dig_nx;
    end
  end

  assign dark = blank[idx] | (flash_en[idx] & (phase == PHASE_OFF));

  // Outputs are computed from the state held before the edge, so the first
  // enabled edge after reset or re-enable shows digit 0 with cnt=0.
  always_comb begin
    state_nx = state;
    phase_nx = phase;
    idx_nx   = idx;
    cnt_nx   = cnt;
    frame_nx = frame_cnt;
    sel_nx   = 6'b111111;
    dig_nx   = 8'hFF;
    advance  = 1'b0;

    if (!disp_en) begin
      state_nx = SHOW;
      idx_nx   = '0;
      cnt_nx   = '0;
    end else begin
      case (state)
        SHOW: begin
          sel_nx = ~(6'b000001 << idx);
          if (!dark) dig_nx = {~dp[idx], seg_decode(value[idx])};
          if (cnt == SHOW_LAST) begin
            cnt_nx = '0;
            if (HAS_BLANK) state_nx = BLANK;
            else           advance  = 1'b1;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        default: begin
          if (cnt == BLANK_LAST) begin
            cnt_nx   = '0;
            state_nx = SHOW;
            advance  = 1'b1;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
      endcase

      // Each 5 -> 0 wrap closes a frame; flash phase flips every FLASH_FRAMES.
      if (advance) begin
        if (idx == 3'd5) begin
          idx_nx = '0;
          if (frame_cnt == FRAME_LAST) begin
            frame_nx = '0;
            phase_nx = (phase == PHASE_ON) ? PHASE_OFF : PHASE_ON;
          end else begin
            frame_nx = frame_cnt + FRM_W'(1);
          end
        end else begin
          idx_nx = idx + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: a frame-position model predicts
// sel/dig per edge into a scoreboard queue that is drained after each edge.
module tb_seg_scan_ctrl;

  localparam int SCAN_DIV     = 4;
  localparam int BLANK_CYC    = 1;
  localparam int FLASH_FRAMES = 2;
  localparam int SLOT         = SCAN_DIV + BLANK_CYC;
  localparam int FRAME        = 6 * SLOT;

  logic       clk;
  logic       rst;
  logic       disp_en;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;
  logic       wr_blank;
  logic [5:0] flash_en;
  logic [7:0] dig;
  logic [5:0] sel;

  typedef struct packed {
    logic [5:0] sel;
    logic [7:0] dig;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    passes = 0;
  string scen   = "init";

  logic [3:0] m_val [6];
  logic [5:0] m_dp;
  logic [5:0] m_blank;
  int         pos;
  int         frames;

  seg_scan_ctrl #(
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYC   (BLANK_CYC),
    .FLASH_FRAMES(FLASH_FRAMES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .disp_en (disp_en),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_dp   (wr_dp),
    .wr_blank(wr_blank),
    .flash_en(flash_en),
    .dig     (dig),
    .sel     (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] ref_seg(input logic [3:0] v);
    case (v)
      4'h0: ref_seg = 8'hC0;  4'h1: ref_seg = 8'hF9;
      4'h2: ref_seg = 8'hA4;  4'h3: ref_seg = 8'hB0;
      4'h4: ref_seg = 8'h99;  4'h5: ref_seg = 8'h92;
      4'h6: ref_seg = 8'h82;  4'h7: ref_seg = 8'hF8;
      4'h8: ref_seg = 8'h80;  4'h9: ref_seg = 8'h90;
      4'hA: ref_seg = 8'h88;  4'hB: ref_seg = 8'h83;
      4'hC: ref_seg = 8'hC6;  4'hD: ref_seg = 8'hA1;
      4'hE: ref_seg = 8'h86;  default: ref_seg = 8'h8E;
    endcase
  endfunction

  function automatic bit flash_off();
    return ((frames / FLASH_FRAMES) % 2) == 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got === want) passes++;
    else $display("[TB] FAIL %s: got %02h, expected %02h at t=%0t", tag, got, want, $time);
  endtask

  // Predict this edge's outputs, push them, clock, then pop and compare.
  task automatic tick();
    exp_t       e;
    exp_t       o;
    int         d;
    int         w;
    logic [7:0] s;
    e.sel = 6'b111111;
    e.dig = 8'hFF;
    if (rst) begin
      for (int i = 0; i < 6; i++) m_val[i] = 4'h0;
      m_dp    = '0;
      m_blank = '0;
      pos     = 0;
      frames  = 0;
    end else begin
      if (disp_en) begin
        d = pos / SLOT;
        w = pos % SLOT;
        if (w < SCAN_DIV) begin
          e.sel = ~(6'b000001 << d);
          if (!(m_blank[d] || (flash_en[d] && flash_off()))) begin
            s = ref_seg(m_val[d]);
            e.dig = {~m_dp[d], s[6:0]};
          end
        end
        pos++;
        if (pos == FRAME) begin
          pos = 0;
          frames++;
        end
      end else begin
        pos = 0;
      end
      if (wr_en && wr_addr <= 3'd5) begin
        m_val[wr_addr]   = wr_data;
        m_dp[wr_addr]    = wr_dp;
        m_blank[wr_addr] = wr_blank;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    checkOutput({scen, ".sel"}, {2'b00, sel}, {2'b00, o.sel});
    checkOutput({scen, ".dig"}, dig, o.dig);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic applyStimulus(input logic [2:0] a, input logic [3:0] d, input logic p, input logic b);
    wr_en    = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_dp    = p;
    wr_blank = b;
    tick();
    wr_en    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    disp_en  = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_dp    = 1'b0;
    wr_blank = 1'b0;
    flash_en = '0;
    pos      = 0;
    frames   = 0;

    scen = "reset";
    run(2);
    rst = 1'b0;

    scen = "scan";
    run(FRAME + 5);

    scen = "write";
    applyStimulus(3'd2, 4'hA, 1'b1, 1'b0);
    applyStimulus(3'd5, 4'h7, 1'b0, 1'b1);
    run(FRAME + 5);

    scen = "badaddr";
    do_reset();
    applyStimulus(3'd6, 4'h3, 1'b1, 1'b1);
    applyStimulus(3'd7, 4'h3, 1'b1, 1'b1);
    run(FRAME);

    scen = "flash";
    do_reset();
    applyStimulus(3'd0, 4'h1, 1'b0, 1'b0);
    flash_en = 6'b000001;
    run(6 * FRAME);

    scen = "disable";
    for (int i = 0; i < FRAME && pos != 3 * SLOT + 1; i++) tick();
    disp_en = 1'b0;
    run(3);
    applyStimulus(3'd4, 4'h9, 1'b1, 1'b0);
    run(2);
    disp_en = 1'b1;
    run(FRAME + 3);

    scen = "random";
    for (int i = 0; i < 400; i++) begin
      disp_en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 29) == 0) flash_en = 6'($urandom);
      if ($urandom_range(0, 2) == 0)
        applyStimulus(3'($urandom_range(0, 7)), 4'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      else
        tick();
    end
    disp_en = 1'b1;

    scen = "midreset";
    applyStimulus(3'd0, 4'h8, 1'b0, 1'b0);
    applyStimulus(3'd3, 4'hE, 1'b1, 1'b0);
    flash_en = 6'b000001;
    for (int i = 0; i < 4 * FRAME && !flash_off(); i++) tick();
    for (int i = 0; i < SLOT && (pos % SLOT) != SCAN_DIV; i++) tick();
    do_reset();
    run(FRAME + 5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
